// File: rtl/cpu_controller.sv
// cpu_controller -- instruction-cycle sequencer for the Simple RISC Machine.
//
// Walks every instruction through fetch (IF1/IF2), PC update (UPD), decode
// (DEC) and the instruction-specific execute/write-back states, and drives
// every strobe consumed by the datapath, PC, IR, address register and RAM.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous active-low reset; forces state RST
//   opcode,op  IR[15:13], IR[12:11] (stable from IF2 onwards)
//   load_pc, reset_pc      PC load enable / next-PC select (1 = 0, 0 = PC+1)
//   addr_sel               memory address mux (1 = PC, 0 = data address)
//   mem_cmd                00 none, 01 read, 10 write
//   load_ir, load_addr     IR / data address register enables
//   nsel                   one-hot register select (001 Rn, 010 Rd, 100 Rm)
//   vsel                   write-back source (00 C, 01 PC, 10 sximm8, 11 mdata)
//   loada/b/c, loads       datapath register enables
//   asel, bsel             A operand = 0 / B operand = sximm5
//   write                  register-file write enable
//   halted                 high while in HALT
module cpu_controller (
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] opcode,
   input  logic [1:0] op,
   output logic       load_pc,
   output logic       reset_pc,
   output logic       addr_sel,
   output logic [1:0] mem_cmd,
   output logic       load_ir,
   output logic       load_addr,
   output logic [2:0] nsel,
   output logic [1:0] vsel,
   output logic       loada,
   output logic       loadb,
   output logic       loadc,
   output logic       loads,
   output logic       asel,
   output logic       bsel,
   output logic       write,
   output logic       halted
);

   // CALC is split three ways (plain, A=0, flags-only) so that every
   // output is a pure function of the state register.
   typedef enum logic [4:0] {
      S_RST, S_IF1, S_IF2, S_UPD, S_DEC, S_WIMM, S_GA, S_GB,
      S_CALC, S_CALC_A, S_CALC_S, S_WREG, S_CADDR, S_LADDR,
      S_RD1, S_RD2, S_GRD, S_STC, S_MWR, S_HALT
   } state_t;

   typedef struct packed {
      logic       load_pc;
      logic       reset_pc;
      logic       addr_sel;
      logic [1:0] mem_cmd;
      logic       load_ir;
      logic       load_addr;
      logic [2:0] nsel;
      logic [1:0] vsel;
      logic       loada;
      logic       loadb;
      logic       loadc;
      logic       loads;
      logic       asel;
      logic       bsel;
      logic       write;
      logic       halted;
   } ctl_t;

   localparam logic [1:0] MEM_RD = 2'b01;
   localparam logic [1:0] MEM_WR = 2'b10;
   localparam logic [2:0] NS_RN  = 3'b001;
   localparam logic [2:0] NS_RD  = 3'b010;
   localparam logic [2:0] NS_RM  = 3'b100;

   state_t state, nxt;
   ctl_t   ctl, ctl_nxt;

   wire [4:0] code  = {opcode, op};
   wire       is_ls = (code == 5'b011_00) || (code == 5'b100_00);

   function automatic ctl_t outs(input state_t s);
      ctl_t c;
      c = '0;
      case (s)
         S_RST:    begin c.reset_pc = 1'b1; c.load_pc = 1'b1; end
         S_IF1:    begin c.addr_sel = 1'b1; c.mem_cmd = MEM_RD; end
         S_IF2:    begin c.addr_sel = 1'b1; c.mem_cmd = MEM_RD; c.load_ir = 1'b1; end
         S_UPD:    c.load_pc = 1'b1;
         S_WIMM:   begin c.nsel = NS_RN; c.vsel = 2'b10; c.write = 1'b1; end
         S_GA:     begin c.nsel = NS_RN; c.loada = 1'b1; end
         S_GB:     begin c.nsel = NS_RM; c.loadb = 1'b1; end
         S_CALC:   c.loadc = 1'b1;
         S_CALC_A: begin c.loadc = 1'b1; c.asel = 1'b1; end
         S_CALC_S: c.loads = 1'b1;
         S_WREG:   begin c.nsel = NS_RD; c.vsel = 2'b00; c.write = 1'b1; end
         S_CADDR:  begin c.bsel = 1'b1; c.loadc = 1'b1; end
         S_LADDR:  c.load_addr = 1'b1;
         S_RD1:    c.mem_cmd = MEM_RD;
         S_RD2:    begin c.mem_cmd = MEM_RD; c.nsel = NS_RD; c.vsel = 2'b11; c.write = 1'b1; end
         S_GRD:    begin c.nsel = NS_RD; c.loadb = 1'b1; end
         S_STC:    begin c.asel = 1'b1; c.loadc = 1'b1; end
         S_MWR:    c.mem_cmd = MEM_WR;
         S_HALT:   c.halted = 1'b1;
         default:  c = '0;
      endcase
      return c;
   endfunction

   always_comb begin
      nxt = state;
      case (state)
         S_RST:  nxt = S_IF1;
         S_IF1:  nxt = S_IF2;
         S_IF2:  nxt = S_UPD;
         S_UPD:  nxt = S_DEC;
         S_DEC: begin
            casez (code)
               5'b110_10: nxt = S_WIMM;
               5'b110_00: nxt = S_GB;
               5'b101_11: nxt = S_GB;
               5'b101_??: nxt = S_GA;
               5'b011_00: nxt = S_GA;
               5'b100_00: nxt = S_GA;
               5'b111_??: nxt = S_HALT;
               default:   nxt = S_IF1;   // unknown code executes as NOP
            endcase
         end
         S_GA:   nxt = is_ls ? S_CADDR : S_GB;
         S_GB: begin
            if (code == 5'b101_01)
               nxt = S_CALC_S;
            else if (code == 5'b110_00 || code == 5'b101_11)
               nxt = S_CALC_A;
            else
               nxt = S_CALC;
         end
         S_CALC, S_CALC_A: nxt = S_WREG;
         S_CALC_S: nxt = S_IF1;
         S_WREG:   nxt = S_IF1;
         S_WIMM:   nxt = S_IF1;
         S_CADDR:  nxt = S_LADDR;
         S_LADDR:  nxt = (opcode == 3'b011) ? S_RD1 : S_GRD;
         S_RD1:    nxt = S_RD2;
         S_RD2:    nxt = S_IF1;
         S_GRD:    nxt = S_STC;
         S_STC:    nxt = S_MWR;
         S_MWR:    nxt = S_IF1;
         S_HALT:   nxt = S_HALT;
         default:  nxt = S_RST;
      endcase
   end

   assign ctl_nxt = outs(nxt);

   // Outputs are registered alongside the state so they decode from the
   // state being entered; they never see opcode/op combinationally.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= S_RST;
         ctl   <= outs(S_RST);
      end else begin
         state <= nxt;
         ctl   <= ctl_nxt;
      end
   end

   assign load_pc   = ctl.load_pc;
   assign reset_pc  = ctl.reset_pc;
   assign addr_sel  = ctl.addr_sel;
   assign mem_cmd   = ctl.mem_cmd;
   assign load_ir   = ctl.load_ir;
   assign load_addr = ctl.load_addr;
   assign nsel      = ctl.nsel;
   assign vsel      = ctl.vsel;
   assign loada     = ctl.loada;
   assign loadb     = ctl.loadb;
   assign loadc     = ctl.loadc;
   assign loads     = ctl.loads;
   assign asel      = ctl.asel;
   assign bsel      = ctl.bsel;
   assign write     = ctl.write;
   assign halted    = ctl.halted;

endmodule

// File: tb/tb_cpu_controller.sv
// tb_cpu_controller -- scoreboard bench for cpu_controller.
//
// The driver classifies each instruction, expands it into the per-cycle list
// of strobes the instruction must produce and queues that list; a monitor
// samples the outputs on every falling edge and compares against the queue.
module tb_cpu_controller;

   typedef struct packed {
      logic       load_pc;
      logic       reset_pc;
      logic       addr_sel;
      logic [1:0] mem_cmd;
      logic       load_ir;
      logic       load_addr;
      logic [2:0] nsel;
      logic [1:0] vsel;
      logic       loada;
      logic       loadb;
      logic       loadc;
      logic       loads;
      logic       asel;
      logic       bsel;
      logic       write;
      logic       halted;
   } ov_t;

   typedef struct {
      ov_t   v;
      string step;
      string ins;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset;
   logic [2:0] opcode;
   logic [1:0] op;
   logic       load_pc, reset_pc, addr_sel, load_ir, load_addr;
   logic [1:0] mem_cmd, vsel;
   logic [2:0] nsel;
   logic       loada, loadb, loadc, loads, asel, bsel, write, halted;

   cpu_controller dut (
      .clk(clk), .reset(reset), .opcode(opcode), .op(op),
      .load_pc(load_pc), .reset_pc(reset_pc), .addr_sel(addr_sel),
      .mem_cmd(mem_cmd), .load_ir(load_ir), .load_addr(load_addr),
      .nsel(nsel), .vsel(vsel), .loada(loada), .loadb(loadb),
      .loadc(loadc), .loads(loads), .asel(asel), .bsel(bsel),
      .write(write), .halted(halted)
   );

   always #5 clk = ~clk;

   ov_t act;
   assign act = {load_pc, reset_pc, addr_sel, mem_cmd, load_ir, load_addr,
                 nsel, vsel, loada, loadb, loadc, loads, asel, bsel, write, halted};

   exp_t expq[$];
   exp_t seq[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   bit   mon_en = 1'b0;
   bit   fin = 1'b0;
   bit   fin_done = 1'b0;

   // Strobes required in each named step of the instruction cycle.
   function automatic ov_t step_v(input string s);
      ov_t e;
      e = '0;
      case (s)
         "RST":   begin e.reset_pc = 1; e.load_pc = 1; end
         "IF1":   begin e.addr_sel = 1; e.mem_cmd = 2'b01; end
         "IF2":   begin e.addr_sel = 1; e.mem_cmd = 2'b01; e.load_ir = 1; end
         "UPD":   e.load_pc = 1;
         "DEC":   e = '0;
         "WIMM":  begin e.nsel = 3'b001; e.vsel = 2'b10; e.write = 1; end
         "GA":    begin e.nsel = 3'b001; e.loada = 1; end
         "GB":    begin e.nsel = 3'b100; e.loadb = 1; end
         "CALC":  e.loadc = 1;
         "CALCA": begin e.loadc = 1; e.asel = 1; end
         "CMP":   e.loads = 1;
         "WREG":  begin e.nsel = 3'b010; e.vsel = 2'b00; e.write = 1; end
         "CADDR": begin e.bsel = 1; e.loadc = 1; end
         "LADDR": e.load_addr = 1;
         "RD1":   e.mem_cmd = 2'b01;
         "RD2":   begin e.mem_cmd = 2'b01; e.nsel = 3'b010; e.vsel = 2'b11; e.write = 1; end
         "GRD":   begin e.nsel = 3'b010; e.loadb = 1; end
         "STC":   begin e.asel = 1; e.loadc = 1; end
         "MWR":   e.mem_cmd = 2'b10;
         "HALT":  e.halted = 1;
         default: e = '0;
      endcase
      return e;
   endfunction

   function automatic string classify(input logic [2:0] oc, input logic [1:0] o);
      logic [4:0] c;
      c = {oc, o};
      casez (c)
         5'b110_10: return "MOVI";
         5'b110_00: return "MOVS";
         5'b101_11: return "MVN";
         5'b101_00: return "ADD";
         5'b101_01: return "CMP";
         5'b101_10: return "AND";
         5'b011_00: return "LDR";
         5'b100_00: return "STR";
         5'b111_??: return "HALT";
         default:   return "NOP";
      endcase
   endfunction

   task automatic add(input string s, input string ins);
      exp_t e;
      e.v = step_v(s); e.step = s; e.ins = ins;
      seq.push_back(e);
   endtask

   // Expand one instruction into its cycle-by-cycle step list.
   task automatic build(input logic [2:0] oc, input logic [1:0] o);
      string c;
      c = classify(oc, o);
      seq.delete();
      add("IF1", c); add("IF2", c); add("UPD", c); add("DEC", c);
      case (c)
         "MOVI": add("WIMM", c);
         "MOVS", "MVN": begin add("GB", c); add("CALCA", c); add("WREG", c); end
         "ADD", "AND": begin add("GA", c); add("GB", c); add("CALC", c); add("WREG", c); end
         "CMP":  begin add("GA", c); add("GB", c); add("CMP", c); end
         "LDR":  begin add("GA", c); add("CADDR", c); add("LADDR", c); add("RD1", c); add("RD2", c); end
         "STR":  begin add("GA", c); add("CADDR", c); add("LADDR", c);
                       add("GRD", c); add("STC", c); add("MWR", c); end
         "HALT": for (int i = 0; i < 40; i++) add("HALT", c);
         default: ;
      endcase
   endtask

   task automatic push_rst();
      exp_t e;
      e.v = step_v("RST"); e.step = "RST"; e.ins = "reset";
      expq.push_back(e);
   endtask

   // Called just after the edge entering IF1. cut=0 runs the whole
   // instruction; cut=n pulls reset while in its n-th cycle.
   task automatic issue(input logic [2:0] oc, input logic [1:0] o, input int cut);
      int n;
      opcode = oc; op = o;
      build(oc, o);
      n = (cut > 0) ? cut : seq.size();
      for (int i = 0; i < n; i++) expq.push_back(seq[i]);
      if (cut == 0) begin
         repeat (n) @(posedge clk);
      end else begin
         repeat (n - 1) @(posedge clk);
         #1 reset = 1'b0;
         push_rst();
         @(posedge clk);
         #1 reset = 1'b1;
         @(posedge clk);
      end
      #1;
   endtask

   always @(negedge clk) begin
      exp_t e;
      cyc++;
      if (fin && !fin_done) begin
         checks++;
         if (expq.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected cycles never observed", expq.size());
         end
         fin_done = 1'b1;
      end else if (mon_en && !fin) begin
         checks++;
         if (expq.size() == 0) begin
            errors++;
            $display("FAIL underflow cyc %0d: act=%05h with no expectation", cyc, act);
         end else begin
            e = expq.pop_front();
            if (act !== e.v) begin
               errors++;
               $display("FAIL %s/%s cyc %0d: act=%05h exp=%05h", e.ins, e.step, cyc, act, e.v);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [4:0] code;
      logic [4:0] r5;
      logic [4:0] dir [9];
      dir = '{5'b110_10, 5'b110_00, 5'b101_11, 5'b101_00, 5'b101_01,
              5'b101_10, 5'b011_00, 5'b100_00, 5'b000_00};

      reset = 1'b0; opcode = 3'b000; op = 2'b00;
      push_rst(); push_rst();
      mon_en = 1'b1;
      @(posedge clk); @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1;

      foreach (dir[i]) begin
         code = dir[i];
         issue(code[4:2], code[1:0], 0);
      end

      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(0, 3) != 0) begin
            code = dir[$urandom_range(0, 7)];
         end else begin
            r5 = 5'($urandom_range(0, 27));   // opcodes 000..110, never HALT
            code = r5;
         end
         issue(code[4:2], code[1:0], 0);
      end

      issue(3'b011, 2'b00, 8);    // reset while in RD1
      issue(3'b100, 2'b00, 9);    // reset while in STC
      issue(3'b110, 2'b10, 0);
      issue(3'b111, 2'b01, 24);   // 20 cycles halted, then reset
      issue(3'b101, 2'b00, 0);

      fin = 1'b1;
      for (int i = 0; i < 10 && !fin_done; i++) @(negedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/cpu_controller.md
# cpu_controller

Instruction-cycle state machine for the Simple RISC Machine CPU. It sits between the instruction register/decoder and the datapath, program counter and memory interface. It sequences reset, fetch, PC update, decode, execute and write-back for MOV, ALU, LDR, STR and HALT. Every control strobe that the datapath, PC, IR, address register and RAM consume comes from this block.

## Interface
- No parameters; state encoding is internal.
- clk  in  1  rising-edge clock, driven from KEY[0]
- reset  in  1  synchronous active-low reset, driven from KEY[1]; 0 at a rising clk edge forces state RST
- opcode  in  3  IR[15:13]
- op  in  2  IR[12:11]
- load_pc, reset_pc  out  1  PC load enable; PC next-value select (1 = 0, 0 = PC+1)
- addr_sel  out  1  memory address mux (1 = PC, 0 = data address register)
- mem_cmd  out  2  00 NONE, 01 READ, 10 WRITE
- load_ir, load_addr  out  1  IR load enable; data address register load enable
- nsel  out  3  one-hot register select: 001 Rn, 010 Rd, 100 Rm
- vsel  out  2  write-back source: 00 C, 01 PC, 10 sximm8, 11 mdata
- loada, loadb, loadc, loads  out  1  datapath register enables
- asel, bsel  out  1  asel 1 = A operand is 0; bsel 1 = B operand is sximm5
- write  out  1  register-file write enable
- halted  out  1  high in HALT

## Operation
- Moore FSM: all outputs decode from the registered state only. Any output not listed for a state is 0; nsel defaults to 000.
- States, their asserted outputs, and next state:
  - RST: reset_pc, load_pc. Next IF1.
  - IF1: addr_sel, mem_cmd=READ. Next IF2.
  - IF2: addr_sel, mem_cmd=READ, load_ir. Next UPD.
  - UPD: load_pc (PC+1). Next DEC.
  - DEC: no outputs. Dispatch on {opcode,op}:
    - 110_10 (MOV imm) → WIMM
    - 110_00 (MOV shift) → GB
    - 101_11 (MVN) → GB
    - 101_xx (ADD, CMP, AND) → GA
    - 011_00 (LDR) → GA
    - 100_00 (STR) → GA
    - 111_xx (HALT) → HALT
    - any other code → IF1 (NOP)
  - WIMM: nsel=Rn, vsel=10, write. Next IF1.
  - GA: nsel=Rn, loada. Next CADDR for LDR/STR, otherwise GB.
  - GB: nsel=Rm, loadb. Next CALC.
  - CALC: loadc. loads asserted only for CMP; CMP also suppresses loadc. asel=1 for MOV shift and MVN. Next IF1 for CMP, otherwise WREG.
  - WREG: nsel=Rd, vsel=00, write. Next IF1.
  - CADDR: bsel, loadc (Rn + sximm5). Next LADDR.
  - LADDR: load_addr. Next RD1 for LDR, GRD for STR.
  - RD1: addr_sel=0, mem_cmd=READ. Next RD2.
  - RD2: mem_cmd=READ, nsel=Rd, vsel=11, write. Next IF1.
  - GRD: nsel=Rd, loadb. Next STC.
  - STC: asel, loadc (C = 0 + Rd). Next MWR.
  - MWR: addr_sel=0, mem_cmd=WRITE. Next IF1.
  - HALT: halted. Stays in HALT until reset.
- In DEC, opcode and op are sampled from the IR already loaded in IF2.

## Timing
- Reset: on a rising edge with reset=0, state becomes RST, regardless of current state, including mid-LDR, mid-STR and HALT. Outputs are then those of RST.
- First edge after reset deasserts: PC is loaded with 0.
- PC increments to n+1 at the UPD→DEC edge, before the instruction at address n executes. PC changes exactly once per executed instruction.
- RAM read is synchronous. mem_cmd=READ is held for two cycles (IF1/IF2, RD1/RD2), and the data is captured in the second cycle.
- Cycle counts from IF1 back to the next IF1:
  - MOV imm: 5
  - MOV shift, MVN, CMP: 7
  - ADD, AND: 8
  - LDR: 9
  - STR: 10
- HALT: the PC has already been incremented past the HALT instruction. No further loads, writes or memory commands occur.
- mem_cmd=WRITE is asserted for exactly one cycle per STR.

## Test plan
- Reset: hold reset=0 for 2 edges, then release. Next edge: reset_pc=1 and load_pc=1 are observed in RST. The following state is IF1 with mem_cmd=01 and addr_sel=1.
- MOV imm: opcode=110, op=10. Sequence IF1, IF2, UPD, DEC, WIMM, with write=1, vsel=10, nsel=001 in WIMM. Back in IF1 after 5 cycles.
- ALU: ADD (101_00) → write=1 in cycle 8 with nsel=010 and vsel=00. CMP (101_01) → loads=1, loadc=0, no write, 7 cycles. MVN (101_11) → asel=1 in CALC.
- LDR (011_00): load_addr pulses in cycle 7. mem_cmd=01 with addr_sel=0 in cycles 8–9. write=1 with vsel=11 in cycle 9.
- STR (100_00): loadb with nsel=010 in GRD. asel=1 in STC. mem_cmd=10 for exactly 1 cycle (cycle 10), then IF1.
- HALT and reset mid-op: 111_00 → halted=1 and stays for 20 cycles with all strobes 0. Assert reset=0 during RD1 → RST on the next edge, and mem_cmd=00 in RST.
